// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types and constants for the FIFO-to-APB command master.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, command header field positions, default access timeout.
package apb_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_POP_HDR  = 4'd1,
    ST_CAP_HDR  = 4'd2,
    ST_WAIT_DAT = 4'd3,
    ST_POP_DAT  = 4'd4,
    ST_CAP_DAT  = 4'd5,
    ST_SETUP    = 4'd6,
    ST_ACCESS   = 4'd7,
    ST_RESP     = 4'd8
  } state_e;

  // Command header layout: [31] write, [30:28] slave index, [ADDR_W-1:0] address.
  localparam int HDR_WR_BIT  = 31;
  localparam int HDR_SEL_MSB = 30;
  localparam int HDR_SEL_LSB = 28;
  localparam int SEL_W       = HDR_SEL_MSB - HDR_SEL_LSB + 1;

  localparam int DEFAULT_TIMEOUT = 255;

  // A slave index is unusable when it addresses a PSEL line that does not exist.
  function automatic logic sel_is_bad(input logic [SEL_W-1:0] idx, input int num_slv);
    return (int'(idx) >= num_slv);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts APB ACCESS cycles and flags the last cycle allowed before abort.
// Latency: o_expired is combinational from the count; the count updates one cycle after i_en.
// Backpressure: none; saturates at TIMEOUT while enabled.
// Ports: clk/rst_n, i_clr (restart count), i_en (one ACCESS cycle elapsing), o_expired.
module apb_timeout_cnt
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT);

  // r_cnt holds the number of ACCESS cycles already completed, so the
  // TIMEOUT-th ACCESS cycle sees r_cnt == TIMEOUT-1.
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = i_en && (r_cnt >= LAST_CYC);

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: drains header/data words from the async FIFO read port and runs them as APB transfers.
// Latency: read 5 cycles from FIFO non-empty to rsp_vld; +2 for a write, +1 per pready wait cycle.
// Backpressure: a held response (rsp_rdy low) blocks all further FIFO pops.
// Ports: FIFO read side (empty, rdata, rdata_en), APB master (psel..pslverr),
//        response port (rsp_vld, rsp_rdy, rsp_data, rsp_err).
module apb_cmd_master
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  // FIFO read port
  input  logic               empty,
  input  logic [31:0]        rdata,
  output logic               rdata_en,
  // APB master
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic [ADDR_W-1:0]  paddr,
  output logic               pwrite,
  output logic [31:0]        pwdata,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr,
  // response
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [31:0]        rsp_data,
  output logic               rsp_err
);

  state_e               r_state;
  state_e               w_state_nxt;

  logic [ADDR_W-1:0]    r_paddr;
  logic                 r_pwrite;
  logic [31:0]          r_pwdata;
  logic [NUM_SLV-1:0]   r_psel;
  logic                 r_penable;
  logic                 r_rdata_en;
  logic [SEL_W-1:0]     r_sel_idx;
  logic                 r_bad_sel;
  logic                 r_rsp_vld;
  logic [31:0]          r_rsp_data;
  logic                 r_rsp_err;

  logic                 w_hdr_wr;
  logic [SEL_W-1:0]     w_hdr_idx;
  logic                 w_hdr_bad;
  logic [SEL_W-1:0]     w_sel_idx;
  logic [NUM_SLV-1:0]   w_sel_oh;
  logic                 w_expired;
  logic                 w_resp_load;
  logic [31:0]          w_rsp_data;
  logic                 w_rsp_err;
  logic                 w_unused_rsvd;

  // Header fields, only meaningful while r_state == ST_CAP_HDR.
  assign w_hdr_wr      = rdata[HDR_WR_BIT];
  assign w_hdr_idx     = rdata[HDR_SEL_MSB:HDR_SEL_LSB];
  assign w_hdr_bad     = sel_is_bad(w_hdr_idx, NUM_SLV);
  assign w_unused_rsvd = ^rdata[27:ADDR_W];

  // psel is registered from the next state, so on the CAP_HDR -> SETUP edge the
  // slave index must come straight from the FIFO word rather than the latch.
  assign w_sel_idx = (r_state == ST_CAP_HDR) ? w_hdr_idx : r_sel_idx;

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_sel_oh[i] = (w_sel_idx == SEL_W'(i));
    end
  end

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state == ST_SETUP),
    .i_en      (r_state == ST_ACCESS),
    .o_expired (w_expired)
  );

  // This block is the only FIFO consumer, so once IDLE/WAIT_DAT/CAP_HDR has seen
  // !empty the word is guaranteed to still be there when the pop fires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (!empty) w_state_nxt = ST_POP_HDR;
      ST_POP_HDR:  w_state_nxt = ST_CAP_HDR;
      ST_CAP_HDR: begin
        // A write whose data word is already queued pops it directly; WAIT_DAT
        // is only visited when the data word is late.
        if (w_hdr_wr)       w_state_nxt = empty ? ST_WAIT_DAT : ST_POP_DAT;
        else if (w_hdr_bad) w_state_nxt = ST_RESP;
        else                w_state_nxt = ST_SETUP;
      end
      ST_WAIT_DAT: if (!empty) w_state_nxt = ST_POP_DAT;
      ST_POP_DAT:  w_state_nxt = ST_CAP_DAT;
      // A bad-select write still consumes its data word to keep the stream aligned.
      ST_CAP_DAT:  w_state_nxt = r_bad_sel ? ST_RESP : ST_SETUP;
      ST_SETUP:    w_state_nxt = ST_ACCESS;
      // pready on the last allowed cycle wins over the timeout.
      ST_ACCESS:   if (pready || w_expired) w_state_nxt = ST_RESP;
      ST_RESP:     if (rsp_rdy) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_resp_load = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

  // Every path into RESP other than a completed transfer (bad select, timeout)
  // reports an error with zero data.
  always_comb begin
    w_rsp_err  = 1'b1;
    w_rsp_data = '0;
    if ((r_state == ST_ACCESS) && pready) begin
      w_rsp_err = pslverr;
      if (!r_pwrite && !pslverr) w_rsp_data = prdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rdata_en <= 1'b0;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_sel_idx  <= '0;
      r_bad_sel  <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rdata_en <= (w_state_nxt == ST_POP_HDR) || (w_state_nxt == ST_POP_DAT);
      r_psel     <= ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS)) ? w_sel_oh : '0;
      r_penable  <= (w_state_nxt == ST_ACCESS);

      if (r_state == ST_CAP_HDR) begin
        r_paddr   <= rdata[ADDR_W-1:0];
        r_pwrite  <= w_hdr_wr;
        r_sel_idx <= w_hdr_idx;
        r_bad_sel <= w_hdr_bad;
      end

      if (r_state == ST_CAP_DAT) begin
        r_pwdata <= rdata;
      end

      if (w_resp_load) begin
        r_rsp_vld  <= 1'b1;
        r_rsp_data <= w_rsp_data;
        r_rsp_err  <= w_rsp_err;
      end else if (r_rsp_vld && rsp_rdy) begin
        r_rsp_vld  <= 1'b0;
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b0;
      end
    end
  end

  assign rdata_en = r_rdata_en;
  assign psel     = r_psel;
  assign penable  = r_penable;
  assign paddr    = r_paddr;
  assign pwrite   = r_pwrite;
  assign pwdata   = r_pwdata;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule
